// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the boot-time program loader.
// Imported by the loader top and its byte-to-word packer.
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    RUN,
    ERR
  } state_e;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and keeps the running XOR checksum.
// word/word_valid are combinational so the owner can register the write on the accepting edge.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [BYTE_W-1:0] checksum
);

  logic [WORD_W-1:0] lanes_q, lanes_d;
  logic [1:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    if (clear) begin
      lanes_d = '0;
      idx_d   = '0;
      csum_d  = '0;
    end else if (en) begin
      lanes_d[{idx_q, 3'b000} +: BYTE_W] = byte_in;
      idx_d  = idx_q + 2'd1;
      csum_d = csum_q ^ byte_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  assign word       = lanes_d;
  assign word_valid = en & ~clear & (idx_q == 2'd3);
  assign checksum   = csum_q;

endmodule

// File: rtl/prog_loader.sv
// UART-fed boot loader: parses SYNC/LEN/DATA/CHK frames, writes words to the CPU top's
// external memory port and holds the CPU in reset until a frame's checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR = 32'h0000_0000,
  parameter logic [LEN_W-1:0]  MAX_WORDS = 16'd64,
  parameter logic [23:0]       TIMEOUT   = 24'd1_000_000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              cpu_reset,
  output logic              Ext_MemWrite,
  output logic [WORD_W-1:0] Ext_WriteData,
  output logic [31:0]       Ext_DataAdr,
  output logic              load_done,
  output logic              load_error,
  output logic [LEN_W-1:0]  words_loaded
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [23:0]       to_cnt_q, to_cnt_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              mem_write_q, mem_write_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [31:0]       adr_q, adr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  words_q, words_d;

  logic [LEN_W-1:0]  len_full;
  logic              timed;
  logic              pk_clear, pk_en, pk_word_valid;
  logic [WORD_W-1:0] pk_word;
  logic [BYTE_W-1:0] pk_csum;

  assign len_full = {rx_data, len_q[7:0]};
  assign timed    = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CHK);
  // Packer is cleared for any legal length, so a zero-length frame checks against 0.
  assign pk_clear = (state_q == LEN_HI) && rx_valid && (len_full <= MAX_WORDS);
  assign pk_en    = (state_q == DATA) && rx_valid;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .en         (pk_en),
    .byte_in    (rx_data),
    .word       (pk_word),
    .word_valid (pk_word_valid),
    .checksum   (pk_csum)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    to_cnt_d    = '0;
    mem_write_d = 1'b0;
    wdata_d     = wdata_q;
    adr_d       = adr_q;
    words_d     = words_q;

    if (timed && !rx_valid) to_cnt_d = to_cnt_q + 24'd1;

    case (state_q)
      IDLE, RUN, ERR: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_d = len_full;
          if (len_full > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            words_d = '0;
            state_d = (len_full == '0) ? CHK : DATA;
          end
        end
      end
      DATA: begin
        if (pk_word_valid) begin
          mem_write_d = 1'b1;
          wdata_d     = pk_word;
          adr_d       = BASE_ADDR + {14'd0, words_q, 2'b00};
          words_d     = words_q + 16'd1;
          if (words_d == len_q) state_d = CHK;
        end
      end
      CHK: begin
        if (rx_valid) state_d = (rx_data == pk_csum) ? RUN : ERR;
      end
      default: state_d = IDLE;
    endcase

    // An arriving byte always beats expiry; any partial word is simply abandoned.
    if (timed && !rx_valid && to_cnt_q == TIMEOUT - 24'd1) begin
      state_d  = IDLE;
      to_cnt_d = '0;
    end

    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == RUN);
    err_d       = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      to_cnt_q    <= '0;
      cpu_reset_q <= 1'b1;
      mem_write_q <= 1'b0;
      wdata_q     <= '0;
      adr_q       <= BASE_ADDR;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      to_cnt_q    <= to_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      adr_q       <= adr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      words_q     <= words_d;
    end
  end

  assign cpu_reset     = cpu_reset_q;
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_WriteData = wdata_q;
  assign Ext_DataAdr   = adr_q;
  assign load_done     = done_q;
  assign load_error    = err_q;
  assign words_loaded  = words_q;

endmodule
